// File: rtl/if_prefetch_queue_pkg.sv
// Shared pipeline definitions: bubble encoding, default PC step, fetch entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;
   localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
   localparam int          DEFAULT_PC_STEP = 4;

   // One fetched instruction with its address and fall-through address.
   // Field order matches the packed entry stored by the prefetch queue.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] npc;
   } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bundle of fetch-control, instruction-memory and decode-side signals of the prefetch queue.
// Latency: n/a (wiring only).
// Backpressure: deq_ready from decode; fetch_en stalls fetch; redirect_valid flushes.
interface if_prefetch_queue_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              fetch_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_target;
   logic              deq_ready;
   logic              deq_valid;
   logic [DATA_W-1:0] deq_instr;
   logic [ADDR_W-1:0] deq_pc;
   logic [ADDR_W-1:0] deq_npc;
   logic [CNT_W-1:0]  occupancy;

   // Queue side
   modport master (
      input  fetch_en, imem_rdata, redirect_valid, redirect_target, deq_ready,
      output imem_addr, deq_valid, deq_instr, deq_pc, deq_npc, occupancy
   );

   // Environment side (hazard logic, instruction memory, decode)
   modport slave (
      output fetch_en, imem_rdata, redirect_valid, redirect_target, deq_ready,
      input  imem_addr, deq_valid, deq_instr, deq_pc, deq_npc, occupancy
   );
endinterface

// File: rtl/if_prefetch_queue_fifo_mem.sv
// DEPTH x W entry register array: one synchronous write port, one combinational read port.
// Latency: write visible on the read port after the writing edge.
// Backpressure: none; the owner decides when to write.
module prefetch_fifo_mem #(
   parameter int W     = 96,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [PTR_W-1:0] i_wr_ptr,
   input  logic [W-1:0]     i_wr_dat,
   input  logic [PTR_W-1:0] i_rd_ptr,
   output logic [W-1:0]     o_rd_dat
);
   logic [W-1:0] r_mem [DEPTH];

   // Storage is never reset; validity is tracked by the owner's count.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_ptr] <= i_wr_dat;
   end

   assign o_rd_dat = r_mem[i_rd_ptr];
endmodule

// File: rtl/if_prefetch_queue.sv
// PC generator feeding a DEPTH-entry prefetch FIFO between instruction ROM and decode.
// Latency: an entry enqueued at edge N is visible at deq_* after edge N (no bypass).
// Backpressure: fetch continues while decode stalls until full; redirect flushes everything.
module if_prefetch_queue
   import pipe_pkg::*;
#(
   parameter int                   DATA_W   = 32,
   parameter int                   ADDR_W   = 32,
   parameter int                   DEPTH    = 4,
   parameter int                   PC_STEP  = DEFAULT_PC_STEP,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   if_prefetch_queue_if.master  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = DATA_W + 2 * ADDR_W;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_deq_vld;
   logic              w_deq;
   logic              w_enq;
   logic [ADDR_W-1:0] w_next_pc;
   logic [ENT_W-1:0]  w_wr_ent;
   logic [ENT_W-1:0]  w_head;

   assign w_deq_vld = (r_count != '0);
   assign w_deq     = w_deq_vld & bus.deq_ready;
   // A full queue still accepts a new entry when the head leaves in the same cycle.
   assign w_enq     = bus.fetch_en & ~bus.redirect_valid &
                      ((r_count < CNT_W'(DEPTH)) | w_deq);
   assign w_next_pc = r_fetch_pc + ADDR_W'(PC_STEP);
   assign w_wr_ent  = {bus.imem_rdata, r_fetch_pc, w_next_pc};

   // Fetch PC, pointers and count; redirect overrides any enqueue or dequeue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else if (bus.redirect_valid) begin
         r_fetch_pc <= bus.redirect_target;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_enq) begin
            r_fetch_pc <= w_next_pc;
            r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
         end
         if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_enq && !w_deq)      r_count <= r_count + CNT_W'(1);
         else if (!w_enq && w_deq) r_count <= r_count - CNT_W'(1);
      end
   end

   prefetch_fifo_mem #(
      .W     (ENT_W),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk      (clk),
      .i_wr_en  (w_enq),
      .i_wr_ptr (r_wr_ptr),
      .i_wr_dat (w_wr_ent),
      .i_rd_ptr (r_rd_ptr),
      .o_rd_dat (w_head)
   );

   // Head outputs come only from storage and collapse to a NOP bubble when empty.
   assign bus.imem_addr = r_fetch_pc;
   assign bus.deq_valid = w_deq_vld;
   assign bus.deq_instr = w_deq_vld ? w_head[ENT_W-1 -: DATA_W] : DATA_W'(NOP_INSTR);
   assign bus.deq_pc    = w_deq_vld ? w_head[2*ADDR_W-1 -: ADDR_W] : '0;
   assign bus.deq_npc   = w_deq_vld ? w_head[ADDR_W-1:0] : '0;
   assign bus.occupancy = r_count;
endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;
   import pipe_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;

   if_prefetch_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

   if_prefetch_queue #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction ROM: word i holds i+1.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign bus.imem_rdata = rom(bus.imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of fetched entries and the next fetch address.
   fetch_entry_t m_q[$];
   logic [31:0]  m_pc = 32'h0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_pc = 32'h0;
      end else if (bus.redirect_valid) begin
         m_q.delete();
         m_pc = bus.redirect_target;
      end else begin
         if (m_q.size() != 0 && bus.deq_ready) void'(m_q.pop_front());
         if (bus.fetch_en && m_q.size() < DEPTH) begin
            m_q.push_back('{instr: rom(m_pc), pc: m_pc, npc: m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the rising edge.
   always @(negedge clk) begin
      fetch_entry_t e;
      e = '0;
      if (m_q.size() != 0) e = m_q[0];
      chk("m_valid", {31'b0, bus.deq_valid}, {31'b0, m_q.size() != 0});
      chk("m_occ",   32'(bus.occupancy), 32'(m_q.size()));
      chk("m_addr",  bus.imem_addr, m_pc);
      chk("m_instr", bus.deq_instr, e.instr);
      chk("m_pc",    bus.deq_pc, e.pc);
      chk("m_npc",   bus.deq_npc, e.npc);
   end

   // Asserts reset between edges, checks the immediate clear, releases after the next falling edge.
   task automatic mid_reset(input logic fe, input logic dr);
      #1 reset = 1'b0;
      #1;
      chk("rst_valid", {31'b0, bus.deq_valid}, 32'h0);
      chk("rst_occ",   32'(bus.occupancy), 32'h0);
      chk("rst_addr",  bus.imem_addr, 32'h0);
      chk("rst_pc",    bus.deq_pc, 32'h0);
      chk("rst_instr", bus.deq_instr, 32'h0);
      bus.fetch_en  = fe;
      bus.deq_ready = dr;
      @(negedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset               = 1'b0;
      bus.fetch_en        = 1'b0;
      bus.deq_ready       = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'h0;
      repeat (2) @(negedge clk);
      chk("init_valid", {31'b0, bus.deq_valid}, 32'h0);
      chk("init_occ",   32'(bus.occupancy), 32'h0);
      chk("init_addr",  bus.imem_addr, 32'h0);
      #1;
      reset         = 1'b1;
      bus.fetch_en  = 1'b1;
      bus.deq_ready = 1'b1;

      // Streaming: one instruction per cycle, occupancy 1.
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("a_pc",    bus.deq_pc, 32'((c - 1) * 4));
         chk("a_npc",   bus.deq_npc, 32'(c * 4));
         chk("a_instr", bus.deq_instr, 32'(c));
         chk("a_occ",   32'(bus.occupancy), 32'd1);
      end

      // Decode stalled: fill to DEPTH, then full+deq, then drain in order.
      mid_reset(1'b1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("b_occ", 32'(bus.occupancy), (k < 4) ? 32'(k) : 32'd4);
      end
      chk("b_addr_hold", bus.imem_addr, 32'd16);
      chk("b_head0", bus.deq_pc, 32'd0);
      #1 bus.deq_ready = 1'b1;
      @(negedge clk);
      chk("b_full_occ",  32'(bus.occupancy), 32'd4);
      chk("b_full_addr", bus.imem_addr, 32'd20);
      chk("b_full_head", bus.deq_pc, 32'd4);
      #1 bus.fetch_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("b_drain_pc", bus.deq_pc, 32'(8 + 4 * k));
      end
      @(negedge clk);
      chk("b_empty_valid", {31'b0, bus.deq_valid}, 32'h0);
      chk("b_empty_occ",   32'(bus.occupancy), 32'h0);

      // Redirect with 3 entries held, decode accepting in the same cycle.
      mid_reset(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("c_occ3", 32'(bus.occupancy), 32'd3);
      #1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h40;
      bus.deq_ready       = 1'b1;
      @(negedge clk);
      chk("c_flush_occ",   32'(bus.occupancy), 32'h0);
      chk("c_flush_valid", {31'b0, bus.deq_valid}, 32'h0);
      chk("c_flush_instr", bus.deq_instr, 32'h0);
      chk("c_flush_pc",    bus.deq_pc, 32'h0);
      chk("c_flush_addr",  bus.imem_addr, 32'h40);
      #1 bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("c_tgt_pc",    bus.deq_pc, 32'h40);
      chk("c_tgt_npc",   bus.deq_npc, 32'h44);
      chk("c_tgt_instr", bus.deq_instr, 32'h11);
      chk("c_tgt_occ",   32'(bus.occupancy), 32'd1);

      // PC wrap at the top of the address space.
      #1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hFFFF_FFFC;
      @(negedge clk);
      chk("d_addr", bus.imem_addr, 32'hFFFF_FFFC);
      #1 bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("d_pc",    bus.deq_pc, 32'hFFFF_FFFC);
      chk("d_npc",   bus.deq_npc, 32'h0);
      chk("d_instr", bus.deq_instr, 32'h4000_0000);
      chk("d_addr0", bus.imem_addr, 32'h0);
      @(negedge clk);
      chk("d_wrap_pc",    bus.deq_pc, 32'h0);
      chk("d_wrap_instr", bus.deq_instr, 32'h1);

      // Random traffic with occasional redirects and asynchronous reset pulses.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(99) == 0) begin
            reset = 1'b0;
            #2 reset = 1'b1;
         end
         bus.fetch_en       = 1'($urandom_range(3) != 0);
         bus.deq_ready      = 1'($urandom_range(1));
         bus.redirect_valid = 1'($urandom_range(19) == 0);
         if ($urandom_range(1) == 1)
            bus.redirect_target = $urandom & 32'hFFFF_FFFC;
         else
            bus.redirect_target = 32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2);
      end
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
